// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg -- shared defines for the general-purpose register file.
//
// Holds the register-file geometry, the enable/disable encodings and the bus
// types used by regfile and regfile_rport.
//
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding), used
// by regfile and regfile_rport.
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int RegNum     = 32;
    localparam int RegNumLog2 = 5;
    localparam int RegWidth   = 32;

    typedef logic [RegNumLog2-1:0] reg_addr_t;   // RegAddrBus
    typedef logic [RegWidth-1:0]   reg_data_t;   // RegBus

    // Whole storage array as one packed value so it can be handed to the
    // read-port instances through a single port.
    typedef logic [RegNum-1:0][RegWidth-1:0] reg_array_t;

    localparam reg_addr_t NOPRegAddr   = 5'b00000;
    localparam reg_data_t ZeroWord     = 32'h00000000;

    localparam logic      RstEnable    = 1'b1;
    localparam logic      WriteEnable  = 1'b1;
    localparam logic      WriteDisable = 1'b0;
    localparam logic      ReadEnable   = 1'b1;
    localparam logic      ReadDisable  = 1'b0;

endpackage

// File: rtl/regfile_rport.sv
// ---------------------------------------------------------------------------
// regfile_rport -- one combinational read port of the register file.
//
// Ports:
//   rst    in   reset; while high the port reads ZeroWord
//   re     in   read enable; low -> ZeroWord
//   raddr  in   read address; register 0 always reads ZeroWord
//   regs   in   current contents of the whole storage array
//   we     in   write enable      (only with REGFILE_BYPASS_EN)
//   waddr  in   write address     (only with REGFILE_BYPASS_EN)
//   wdata  in   write data        (only with REGFILE_BYPASS_EN)
//   rdata  out  read data, zero-cycle latency
//
// Macro REGFILE_BYPASS_EN: when defined, a read of the register being written
// in the same cycle returns the incoming write data instead of the stored
// value. When undefined, the stored (pre-write) value is returned.
// ---------------------------------------------------------------------------
module regfile_rport
    import regfile_pkg::*;
(
    input  logic       rst,
    input  logic       re,
    input  reg_addr_t  raddr,
    input  reg_array_t regs,
`ifdef REGFILE_BYPASS_EN
    input  logic       we,
    input  reg_addr_t  waddr,
    input  reg_data_t  wdata,
`endif
    output reg_data_t  rdata
);

    always_comb begin
        rdata = ZeroWord;
        if (rst != RstEnable && re == ReadEnable && raddr != NOPRegAddr) begin
            rdata = regs[raddr];
`ifdef REGFILE_BYPASS_EN
            // raddr is already known non-zero here, so a match also
            // guarantees waddr != 0: writes to r0 are never forwarded.
            if (we == WriteEnable && waddr == raddr) begin
                rdata = wdata;
            end
`endif
        end
    end

endmodule

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile -- 32 x 32-bit general-purpose register file, one write port and
// two independent combinational read ports.
//
// Ports:
//   clk     in   clock, all state changes on the rising edge
//   rst     in   asynchronous active-high reset, clears every register
//   we      in   write-back write enable
//   waddr   in   write register address
//   wdata   in   write data
//   re1     in   read port 1 enable
//   raddr1  in   read port 1 address
//   rdata1  out  read port 1 data
//   re2     in   read port 2 enable
//   raddr2  in   read port 2 address
//   rdata2  out  read port 2 data
//
// Register 0 is hardwired to zero: writes to it are dropped and it always
// reads ZeroWord.
//
// Macro REGFILE_BYPASS_EN: enables same-cycle write-to-read forwarding in both
// read ports. Without it, a newly written value is visible the cycle after
// the write edge.
// ---------------------------------------------------------------------------
module regfile
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      we,
    input  reg_addr_t waddr,
    input  reg_data_t wdata,
    input  logic      re1,
    input  reg_addr_t raddr1,
    output reg_data_t rdata1,
    input  logic      re2,
    input  reg_addr_t raddr2,
    output reg_data_t rdata2
);

    reg_array_t regs_q;
    reg_array_t regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we != WriteDisable && waddr != NOPRegAddr) begin
            regs_d[waddr] = wdata;
        end
    end

    // Entry 0 is only ever loaded with zero, so it stays constant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_rport u_rport1 (
        .rst   (rst),
        .re    (re1),
        .raddr (raddr1),
        .regs  (regs_q),
`ifdef REGFILE_BYPASS_EN
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
`endif
        .rdata (rdata1)
    );

    regfile_rport u_rport2 (
        .rst   (rst),
        .re    (re2),
        .raddr (raddr2),
        .regs  (regs_q),
`ifdef REGFILE_BYPASS_EN
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
`endif
        .rdata (rdata2)
    );

endmodule

// File: tb/tb_regfile.sv
// ---------------------------------------------------------------------------
// tb_regfile -- self-checking bench for regfile.
// Vector table for the single-cycle behaviour, hand-written sequences for
// reset. Expected read data is queued when stimulus is applied and popped
// when the combinational outputs are sampled.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile;
    import regfile_pkg::*;

    logic      clk;
    logic      rst;
    logic      we;
    reg_addr_t waddr;
    reg_data_t wdata;
    logic      re1;
    reg_addr_t raddr1;
    reg_data_t rdata1;
    logic      re2;
    reg_addr_t raddr2;
    reg_data_t rdata2;

    regfile dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    // Period 20: rising edges at 10, 30, ...; falling edges at 20, 40, ...
    initial clk = 1'b0;
    always #10 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string     name;
        logic      we;
        reg_addr_t waddr;
        reg_data_t wdata;
        logic      re1;
        reg_addr_t raddr1;
        logic      re2;
        reg_addr_t raddr2;
        reg_data_t exp1;
        reg_data_t exp2;
    } vec_t;

    typedef struct {
        string     name;
        reg_data_t exp1;
        reg_data_t exp2;
    } sb_t;

    sb_t sb_q[$];
    int  pass_cnt = 0;
    int  chk_cnt  = 0;

    function automatic vec_t mk(string nm, logic w, reg_addr_t wa, reg_data_t wd,
                                logic r1, reg_addr_t a1, logic r2, reg_addr_t a2,
                                reg_data_t e1, reg_data_t e2);
        vec_t v;
        v.name = nm;  v.we = w;   v.waddr = wa;  v.wdata = wd;
        v.re1 = r1;   v.raddr1 = a1;
        v.re2 = r2;   v.raddr2 = a2;
        v.exp1 = e1;  v.exp2 = e2;
        return v;
    endfunction

    task automatic push_exp(string nm, reg_data_t e1, reg_data_t e2);
        sb_t s;
        s.name = nm; s.exp1 = e1; s.exp2 = e2;
        sb_q.push_back(s);
    endtask

    task automatic check_outputs();
        sb_t s;
        if (sb_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL scoreboard_empty: got no expected entry, required one");
            return;
        end
        s = sb_q.pop_front();
        chk_cnt++;
        if (rdata1 === s.exp1) pass_cnt++;
        else $display("FAIL %s.rdata1: got %h, required %h", s.name, rdata1, s.exp1);
        chk_cnt++;
        if (rdata2 === s.exp2) pass_cnt++;
        else $display("FAIL %s.rdata2: got %h, required %h", s.name, rdata2, s.exp2);
    endtask

    task automatic drive(logic w, reg_addr_t wa, reg_data_t wd,
                         logic r1, reg_addr_t a1, logic r2, reg_addr_t a2);
        we = w; waddr = wa; wdata = wd;
        re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
    endtask

    vec_t vecs[$];

    // Watchdog: the bench is purely clock-stepped, this only guards against
    // a simulator-level stall.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // -------- reset state --------
        rst = 1'b1;
        drive(WriteEnable, 5'd5, 32'h11111111, ReadEnable, 5'd5, ReadEnable, 5'd31);
        push_exp("reset_state", ZeroWord, ZeroWord);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        drive(WriteDisable, 5'd0, 32'h0, ReadDisable, 5'd0, ReadDisable, 5'd0);

        // -------- vector table --------
        vecs.push_back(mk("wr_r5",        1, 5'd5,  32'hDEADBEEF, 1, 5'd5,  0, 5'd5,
                          BYP ? 32'hDEADBEEF : 32'h0, 32'h0));
        vecs.push_back(mk("rd_r5",        0, 5'd0,  32'h0,        1, 5'd5,  1, 5'd5,
                          32'hDEADBEEF, 32'hDEADBEEF));
        vecs.push_back(mk("wr_r0",        1, 5'd0,  32'hFFFFFFFF, 1, 5'd0,  1, 5'd0,
                          32'h0, 32'h0));
        vecs.push_back(mk("rd_r0",        0, 5'd0,  32'h0,        1, 5'd0,  1, 5'd0,
                          32'h0, 32'h0));
        vecs.push_back(mk("wr_r7_init",   1, 5'd7,  32'h00000001, 0, 5'd7,  0, 5'd7,
                          32'h0, 32'h0));
        vecs.push_back(mk("same_cyc_r7",  1, 5'd7,  32'h12345678, 1, 5'd7,  1, 5'd7,
                          BYP ? 32'h12345678 : 32'h1, BYP ? 32'h12345678 : 32'h1));
        vecs.push_back(mk("rd_r7_next",   0, 5'd0,  32'h0,        1, 5'd7,  1, 5'd7,
                          32'h12345678, 32'h12345678));
        vecs.push_back(mk("wr_r3",        1, 5'd3,  32'hA5A5A5A5, 0, 5'd3,  0, 5'd3,
                          32'h0, 32'h0));
        vecs.push_back(mk("rd_r3_re2off", 0, 5'd0,  32'h0,        1, 5'd3,  0, 5'd3,
                          32'hA5A5A5A5, 32'h0));
        vecs.push_back(mk("rd_r3_re2on",  0, 5'd0,  32'h0,        1, 5'd5,  1, 5'd3,
                          32'hDEADBEEF, 32'hA5A5A5A5));
        vecs.push_back(mk("wr_r9_gated",  0, 5'd9,  32'h00000055, 1, 5'd9,  1, 5'd9,
                          32'h0, 32'h0));
        vecs.push_back(mk("rd_r9_after",  0, 5'd0,  32'h0,        1, 5'd9,  1, 5'd7,
                          32'h0, 32'h12345678));
        vecs.push_back(mk("byp_one_port", 1, 5'd10, 32'h0000CAFE, 1, 5'd10, 1, 5'd3,
                          BYP ? 32'h0000CAFE : 32'h0, 32'hA5A5A5A5));
        vecs.push_back(mk("byp_re_off",   1, 5'd10, 32'h0000BEEF, 1, 5'd10, 0, 5'd10,
                          BYP ? 32'h0000BEEF : 32'h0000CAFE, 32'h0));
        vecs.push_back(mk("rd_r10",       0, 5'd0,  32'h0,        1, 5'd10, 1, 5'd10,
                          32'h0000BEEF, 32'h0000BEEF));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata,
                  vecs[i].re1, vecs[i].raddr1, vecs[i].re2, vecs[i].raddr2);
            push_exp(vecs[i].name, vecs[i].exp1, vecs[i].exp2);
            #1;
            check_outputs();
        end

        // -------- fill r1..r31 with their index --------
        for (int i = 1; i < RegNum; i++) begin
            @(negedge clk);
            drive(WriteEnable, reg_addr_t'(i), reg_data_t'(i),
                  ReadDisable, 5'd0, ReadDisable, 5'd0);
        end
        @(negedge clk);
        drive(WriteDisable, 5'd0, 32'h0, ReadEnable, 5'd31, ReadEnable, 5'd1);
        push_exp("fill_check", 32'd31, 32'd1);
        #1;
        check_outputs();

        // -------- async reset pulse between edges --------
        #2;
        rst = 1'b1;
        push_exp("rst_mid_cycle", ZeroWord, ZeroWord);
        #1;
        check_outputs();
        #1;
        rst = 1'b0;
        // Still before the next rising edge: contents must already be gone.
        raddr1 = 5'd17;
        raddr2 = 5'd2;
        push_exp("rst_cleared_store", ZeroWord, ZeroWord);
        #1;
        check_outputs();

        // -------- write issued during reset is discarded --------
        @(negedge clk);
        rst = 1'b1;
        drive(WriteEnable, 5'd4, 32'h00000077, ReadEnable, 5'd4, ReadEnable, 5'd4);
        push_exp("wr_during_rst", ZeroWord, ZeroWord);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        drive(WriteDisable, 5'd0, 32'h0, ReadEnable, 5'd4, ReadEnable, 5'd31);
        push_exp("after_rst_r4", ZeroWord, ZeroWord);
        #1;
        check_outputs();

        // -------- first write after reset is normal --------
        @(negedge clk);
        drive(WriteEnable, 5'd4, 32'h00000044, ReadDisable, 5'd4, ReadDisable, 5'd4);
        @(negedge clk);
        drive(WriteDisable, 5'd0, 32'h0, ReadEnable, 5'd4, ReadEnable, 5'd4);
        push_exp("first_wr_after_rst", 32'h00000044, 32'h00000044);
        #1;
        check_outputs();

        if (sb_q.size() != 0) begin
            chk_cnt++;
            $display("FAIL scoreboard_left: got %0d entries, required 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter-like constants, from the shared defines file:
- RegNum, 32, number of general registers.
- RegNumLog2, 5, address width.
- RegWidth, 32, data width.
- NOPRegAddr, 5'b00000, hardwired-zero register address.
- ZeroWord, 32'h00000000, reset and disabled-read value.
REQ-002 Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high (`RstEnable).
- we  in  1  write-back write enable; driven by the MEM/WB register's wb_we.
- waddr  in  5  write register address; driven by wb_waddr.
- wdata  in  32  write data; driven by wb_wdata.
- re1  in  1  read port 1 enable.
- raddr1  in  5  read port 1 address.
- rdata1  out  32  read port 1 data.
- re2  in  1  read port 2 enable.
- raddr2  in  5  read port 2 address.
- rdata2  out  32  read port 2 data.

Function
REQ-003 The block SHALL hold 32 x 32-bit registers, indexed 0..31.
REQ-004 On a rising clk with rst low, we high and waddr != 0, the block SHALL write wdata into register waddr.
REQ-005 Writes with we low, or with waddr == 0, SHALL leave all registers unchanged.
REQ-006 Register 0 SHALL always read ZeroWord, regardless of any write attempt.
REQ-007 Read ports SHALL be combinational, with zero-cycle latency from raddrN/reN to rdataN.
REQ-008 With reN low, rdataN SHALL be ZeroWord.
REQ-009 With reN high and raddrN == 0, rdataN SHALL be ZeroWord.
REQ-010 With reN high, raddrN != 0 and no bypass hit, rdataN SHALL be the stored value of register raddrN.
REQ-011 The two read ports SHALL be fully independent; both ports may address the same register in the same cycle.
REQ-012 Both ports reading the same address SHALL return identical data.
REQ-013 There SHALL be at most one write per cycle. The write port has no conflict rule, because only one writer exists.

Reset
REQ-014 While rst is high, all 32 registers SHALL be cleared to ZeroWord asynchronously, without waiting for a clock edge.
REQ-015 While rst is high, rdata1 and rdata2 SHALL read ZeroWord, and no write SHALL take effect.
REQ-016 If rst asserts in the same cycle as a write, the write SHALL be lost.
REQ-017 After rst deasserts, the first rising edge with we high SHALL perform a normal write.

Configuration
REQ-018 The macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-019 With REGFILE_BYPASS_EN defined, a port SHALL return wdata instead of the stored value when all of these hold in the same cycle:
- reN high;
- we high;
- raddrN == waddr;
- waddr != 0;
- rst low.
REQ-020 With REGFILE_BYPASS_EN defined, the bypass SHALL apply to each port independently and may hit on both ports at once.
REQ-021 Without REGFILE_BYPASS_EN, reads SHALL return the pre-write stored value; the new value becomes visible the cycle after the edge.
REQ-022 Reset, the zero-register rules and disabled-read behaviour SHALL be identical in both configurations.

Structure
REQ-023 The following SHALL live in the shared defines file, alongside the existing RegAddrBus, RegBus, WriteDisable and ZeroWord:
- RegNum, RegNumLog2, NOPRegAddr;
- ReadEnable and ReadDisable.
REQ-024 A read-port sub-module, regfile_rport, is natural. It SHALL implement the REQ-008..REQ-010 and REQ-019 mux, and SHALL be instantiated twice.
REQ-025 The storage array and the write logic SHALL remain in regfile.

Verification
REQ-026 Basic write/read: write 32'hDEADBEEF to r5, then next cycle set re1=1, raddr1=5 -> rdata1 = 32'hDEADBEEF.
REQ-027 Zero register: we=1, waddr=0, wdata=32'hFFFFFFFF, then read r0 on both ports -> rdata1 = rdata2 = 32'h00000000.
REQ-028 Same-cycle read of the written register: we=1, waddr=7, wdata=32'h12345678, while re1=re2=1 and raddr1=raddr2=7, with r7 previously 32'h1.
- With REGFILE_BYPASS_EN: both ports = 32'h12345678 in that cycle.
- Without REGFILE_BYPASS_EN: both ports = 32'h1 in that cycle, then 32'h12345678 next cycle.
REQ-029 Disabled read: r3 = 32'hA5A5A5A5, re2=0, raddr2=3 -> rdata2 = 32'h0; raise re2 -> rdata2 = 32'hA5A5A5A5.
REQ-030 Reset: fill r1..r31 with their index values, then assert rst mid-cycle with no clock edge -> every read returns 32'h0 immediately. A write issued during rst is discarded.
REQ-031 Write gating: a write with we=0 to r9 (wdata 32'h55) leaves r9 at its prior value 32'h0.
